mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle main controller for the single-memory MIPS datapath. It steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB states and drives every datapath control: write enables, ALU op, mux selects,
//  and the immediate-extender mode EXTsel. It also counts retired instructions and flags illegal opcodes.
// PARAMETERS
//  CNT_W   32  width of retire counter instr_cnt
// PORTS
//  clk        in   1   system clock, rising edge; single clock domain
//  reset      in   1   asynchronous, active-high reset
//  opcode     in   6   IR[31:26], valid from DECODE onward
//  funct      in   6   IR[5:0]
//  zero       in   1   ALU zero flag, sampled in BRANCH
//  mem_ready  in   1   memory handshake (only with MC_CTRL_STALL_EN; otherwise port absent)
//  PCWr       out  1   PC write enable
//  IRWr       out  1   IR write enable
//  RegWr      out  1   GRF write enable
//  MemWr      out  1   DM write enable
//  EXTsel     out  2   00 zero-ext, 01 sign-ext, 10 imm<<16
//  ALUop      out  3   000 add, 001 sub, 010 or, 011 pass-B
//  ALUSrcB    out  1   0 rt data, 1 EXT output
//  RegDst     out  2   00 rt, 01 rd, 10 $31
//  MemtoReg   out  2   00 ALU, 01 DM, 10 PC+4
//  PCsel      out  2   00 PC+4, 01 branch target, 10 j target, 11 rs (jr)
//  illegal    out  1   one-cycle pulse in DECODE on an unsupported instruction
//  instr_cnt  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  State register updates on posedge clk; reset forces state=FETCH, instr_cnt=0, illegal=0 immediately.
//  Outputs are decoded combinationally from state and opcode/funct. While reset is high, every write
//  enable (PCWr/IRWr/RegWr/MemWr) is 0. Every other output is 0 in any state that does not assign it.
//  Supported: addu subu (op 0, funct 21/23), ori 0D, lui 0F, lw 23, sw 2B, beq 04, j 02, jal 03,
//  jr (op 0, funct 08), nop (word 0).
//  FETCH: IRWr=1, PCWr=1, PCsel=00 -> DECODE.
//  DECODE: EXTsel=01, ALUop=000 (branch target precompute); dispatch: R->EXEC_R; ori/lui->EXEC_I;
//   lw/sw->MEM_ADDR; beq->BRANCH; j/jal/jr->JUMP; nop->FETCH (retires); other->FETCH with illegal=1 (no retire).
//  EXEC_R: ALUSrcB=0, ALUop add/sub -> WB_R. WB_R: RegWr=1, RegDst=01, MemtoReg=00 -> FETCH.
//  EXEC_I: ALUSrcB=1; ori: EXTsel=00, ALUop=010; lui: EXTsel=10, ALUop=011 -> WB_I.
//  WB_I: same selects held, RegWr=1, RegDst=00 -> FETCH.
//  MEM_ADDR: EXTsel=01, ALUSrcB=1, ALUop=000; lw->MEM_RD, sw->MEM_WR.
//  MEM_RD -> MEM_WB. MEM_WB: RegWr=1, RegDst=00, MemtoReg=01 -> FETCH. MEM_WR: MemWr=1 -> FETCH.
//  BRANCH: ALUSrcB=0, ALUop=001; PCWr=zero, PCsel=01 -> FETCH.
//  JUMP: PCWr=1, PCsel=10 (j/jal) or 11 (jr); jal also RegWr=1, RegDst=10, MemtoReg=10 -> FETCH.
//  Latency: beq/j/jal/jr 3 cycles, R/ori/lui/sw 4 cycles, lw 5 cycles, nop 2 cycles.
//  instr_cnt increments by 1 on the transition into FETCH from a completing state; it wraps at 2^CNT_W-1 -> 0.
//  Reset mid-instruction abandons it (no retire, no writes); the first post-reset cycle is FETCH.
// CONFIGURATION
//  MC_CTRL_STALL_EN defined: mem_ready port exists. FETCH, MEM_RD and MEM_WR hold their state while
//   mem_ready=0. Only FETCH asserts IRWr/PCWr, and only MEM_WR asserts MemWr, and only in the advancing
//   cycle (mem_ready=1), so each write happens exactly once.
//  Not defined: memory is single-cycle, there is no mem_ready port, and the timing is as listed above.
// STRUCTURE
//  Shared package mc_pkg (mc_pkg.vh): state localparams (4-bit), opcode/funct constants,
//   EXTsel/ALUop/PCsel/RegDst/MemtoReg encodings; the datapath and bench include it too.
//  Sub-module mc_decode: combinational opcode/funct -> instruction-class one-hot (r_alu, imm_alu, load,
//   store, branch, jump, nop, illegal); the FSM and output decode stay in mc_ctrl.
// TESTING
//  reset high mid-MEM_RD, release -> next cycle FETCH, IRWr=1, instr_cnt=0, RegWr never pulsed.
//  lui (op 0F) -> 4 cycles; in EXEC_I/WB_I EXTsel=10, ALUop=011, RegWr=1 only in WB_I; instr_cnt+1.
//  ori then lw -> EXTsel=00 in EXEC_I; EXTsel=01 in MEM_ADDR; MemtoReg=01, RegWr=1 in MEM_WB; 9 cycles total.
//  beq zero=1 then zero=0 -> PCWr=1/PCsel=01 in the first BRANCH, PCWr=0 in the second; both 3 cycles.
//  opcode 3F -> illegal=1 one cycle in DECODE, back to FETCH, instr_cnt unchanged; jal -> RegDst=10, MemtoReg=10.
//  STALL_EN: sw with mem_ready=0 for 3 cycles in MEM_WR -> MemWr=1 exactly once, on the mem_ready=1 cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS main controller.
//   - state_t            : 4-bit FSM state encoding
//   - OP_* / FN_*        : opcode and funct field constants
//   - EXT_* ALU_* PC_* DST_* M2R_* : datapath control encodings
//   - instr_class_t      : one-hot instruction class from mc_decode
// Optional feature macro used by the slice: MC_CTRL_STALL_EN (memory handshake).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_HI16  = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_DM    = 2'b01;
  localparam logic [1:0] M2R_PC4   = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  typedef struct packed {
    logic r_alu;
    logic imm_alu;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic nop;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bundle.
//   inputs to controller : opcode[5:0], funct[5:0], zero, mem_ready (MC_CTRL_STALL_EN only)
//   outputs              : PCWr IRWr RegWr MemWr EXTsel ALUop ALUSrcB RegDst MemtoReg PCsel
//                          illegal instr_cnt[CNT_W-1:0]
// modport master = controller side, modport slave = datapath side.
interface mc_ctrl_if #(parameter int CNT_W = 32);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
`ifdef MC_CTRL_STALL_EN
  logic             mem_ready;
`endif
  logic             PCWr;
  logic             IRWr;
  logic             RegWr;
  logic             MemWr;
  logic [1:0]       EXTsel;
  logic [2:0]       ALUop;
  logic             ALUSrcB;
  logic [1:0]       RegDst;
  logic [1:0]       MemtoReg;
  logic [1:0]       PCsel;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, funct, zero,
`ifdef MC_CTRL_STALL_EN
    input  mem_ready,
`endif
    output PCWr, IRWr, RegWr, MemWr, EXTsel, ALUop, ALUSrcB,
           RegDst, MemtoReg, PCsel, illegal, instr_cnt
  );

  modport slave (
    output opcode, funct, zero,
`ifdef MC_CTRL_STALL_EN
    output mem_ready,
`endif
    input  PCWr, IRWr, RegWr, MemWr, EXTsel, ALUop, ALUSrcB,
           RegDst, MemtoReg, PCsel, illegal, instr_cnt
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational opcode/funct -> one-hot instruction class.
//   i_opcode[5:0], i_funct[5:0] in; o_cls (instr_class_t) out.
// Exactly one class bit is set for any input; anything unsupported is 'illegal'.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output instr_class_t o_cls
);

  // Opcode 0 is further split on funct: ALU ops, jr, and the all-zero nop.
  always_comb begin
    o_cls = '0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU, FN_SUBU: o_cls.r_alu   = 1'b1;
          FN_JR:            o_cls.jump    = 1'b1;
          FN_NOP:           o_cls.nop     = 1'b1;
          default:          o_cls.illegal = 1'b1;
        endcase
      end
      OP_ORI, OP_LUI:       o_cls.imm_alu = 1'b1;
      OP_LW:                o_cls.load    = 1'b1;
      OP_SW:                o_cls.store   = 1'b1;
      OP_BEQ:               o_cls.branch  = 1'b1;
      OP_J, OP_JAL:         o_cls.jump    = 1'b1;
      default:              o_cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the single-memory MIPS datapath.
//   clk, reset (async, active-high) plain ports; everything else via mc_ctrl_if.master:
//   opcode/funct/zero (+ mem_ready with MC_CTRL_STALL_EN) in; write enables, mux selects,
//   ALUop, EXTsel, illegal pulse and retire counter instr_cnt out.
// Optional feature macro: MC_CTRL_STALL_EN -- FETCH/MEM_RD/MEM_WR wait for mem_ready.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     reset,
  mc_ctrl_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  instr_class_t     w_cls;
  logic             w_ready;
  logic             w_retire;
  logic             w_pcwr, w_irwr, w_regwr, w_memwr;

  mc_decode u_decode (
    .i_opcode (bus.opcode),
    .i_funct  (bus.funct),
    .o_cls    (w_cls)
  );

`ifdef MC_CTRL_STALL_EN
  assign w_ready = bus.mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  // State register and retire counter; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Next-state and output decode. Write enables are computed here and gated by
  // reset below so nothing is written while reset is held. w_retire is only set
  // on the transitions that complete an instruction back into FETCH.
  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_pcwr       = 1'b0;
    w_irwr       = 1'b0;
    w_regwr      = 1'b0;
    w_memwr      = 1'b0;
    bus.EXTsel   = EXT_ZERO;
    bus.ALUop    = ALU_ADD;
    bus.ALUSrcB  = 1'b0;
    bus.RegDst   = DST_RT;
    bus.MemtoReg = M2R_ALU;
    bus.PCsel    = PC_PLUS4;
    bus.illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_ready) begin
          w_irwr = 1'b1;
          w_pcwr = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.EXTsel = EXT_SIGN;
        bus.ALUop  = ALU_ADD;
        if (w_cls.r_alu)                    w_next = S_EXEC_R;
        else if (w_cls.imm_alu)             w_next = S_EXEC_I;
        else if (w_cls.load || w_cls.store) w_next = S_MEM_ADDR;
        else if (w_cls.branch)              w_next = S_BRANCH;
        else if (w_cls.jump)                w_next = S_JUMP;
        else if (w_cls.nop) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_cls.illegal) begin
          w_next      = S_FETCH;
          bus.illegal = 1'b1;
        end
      end
      S_EXEC_R: begin
        bus.ALUop = (bus.funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        w_next    = S_WB_R;
      end
      S_WB_R: begin
        w_regwr    = 1'b1;
        bus.RegDst = DST_RD;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_EXEC_I, S_WB_I: begin
        bus.ALUSrcB = 1'b1;
        if (bus.opcode == OP_LUI) begin
          bus.EXTsel = EXT_HI16;
          bus.ALUop  = ALU_PASSB;
        end else begin
          bus.EXTsel = EXT_ZERO;
          bus.ALUop  = ALU_OR;
        end
        if (r_state == S_EXEC_I) begin
          w_next = S_WB_I;
        end else begin
          w_regwr  = 1'b1;
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        bus.EXTsel  = EXT_SIGN;
        bus.ALUSrcB = 1'b1;
        bus.ALUop   = ALU_ADD;
        w_next      = w_cls.load ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (w_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_regwr      = 1'b1;
        bus.MemtoReg = M2R_DM;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_MEM_WR: begin
        if (w_ready) begin
          w_memwr  = 1'b1;
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_BRANCH: begin
        bus.ALUop = ALU_SUB;
        w_pcwr    = bus.zero;
        bus.PCsel = PC_BRANCH;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      S_JUMP: begin
        w_pcwr    = 1'b1;
        bus.PCsel = (bus.opcode == OP_RTYPE) ? PC_RS : PC_JUMP;
        if (bus.opcode == OP_JAL) begin
          w_regwr      = 1'b1;
          bus.RegDst   = DST_RA;
          bus.MemtoReg = M2R_PC4;
        end
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.PCWr      = w_pcwr  & ~reset;
  assign bus.IRWr      = w_irwr  & ~reset;
  assign bus.RegWr     = w_regwr & ~reset;
  assign bus.MemWr     = w_memwr & ~reset;
  assign bus.instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Each cycle the stimulus pushes the
// hand-computed control word and counter value it expects; a monitor on the
// falling edge pops and compares. Counter width is reduced to 4 bits so the
// wrap from 15 to 0 is reachable. Define MC_CTRL_STALL_EN to add the stall test.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CW)) bus ();

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [16:0]   expCtlQ[$];
  logic [CW-1:0] expCntQ[$];
  string         tagQ[$];
  int            testsRun    = 0;
  int            testsFailed = 0;
  logic [CW-1:0] expCnt      = '0;

  // Control word layout: PCWr IRWr RegWr MemWr EXTsel ALUop ALUSrcB RegDst MemtoReg PCsel illegal
  function automatic logic [16:0] mk(input logic pcwr, input logic irwr, input logic regwr,
                                     input logic memwr, input logic [1:0] ext, input logic [2:0] alu,
                                     input logic srcb, input logic [1:0] dst, input logic [1:0] m2r,
                                     input logic [1:0] pcs, input logic ill);
    return {pcwr, irwr, regwr, memwr, ext, alu, srcb, dst, m2r, pcs, ill};
  endfunction

  task automatic checkOutput(input logic [16:0] eCtl, input logic [CW-1:0] eCnt, input string tag);
    logic [16:0] aCtl;
    aCtl = {bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.EXTsel, bus.ALUop, bus.ALUSrcB,
            bus.RegDst, bus.MemtoReg, bus.PCsel, bus.illegal};
    testsRun++;
    if (aCtl !== eCtl || bus.instr_cnt !== eCnt) begin
      testsFailed++;
      $display("[TB] FAIL %s: ctl=%05h cnt=%0d, expected ctl=%05h cnt=%0d",
               tag, aCtl, bus.instr_cnt, eCtl, eCnt);
    end
  endtask

  // Monitor: one expected word per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (expCtlQ.size() != 0) begin
      checkOutput(expCtlQ.pop_front(), expCntQ.pop_front(), tagQ.pop_front());
    end
  end

  task automatic step(input logic [16:0] ctl, input string tag);
    expCtlQ.push_back(ctl);
    expCntQ.push_back(expCnt);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
  endtask

  task automatic fetchDecode(input logic ill, input string tag);
    step(mk(1,1,0,0,2'b00,3'b000,0,2'b00,2'b00,2'b00,0), {tag, "_fetch"});
    step(mk(0,0,0,0,2'b01,3'b000,0,2'b00,2'b00,2'b00,ill), {tag, "_decode"});
  endtask

  task automatic runR(input logic [5:0] fn, input logic [2:0] alu, input string tag);
    applyStimulus(OP_RTYPE, fn, 1'b0);
    fetchDecode(1'b0, tag);
    step(mk(0,0,0,0,2'b00,alu,0,2'b00,2'b00,2'b00,0), {tag, "_exec"});
    step(mk(0,0,1,0,2'b00,3'b000,0,2'b01,2'b00,2'b00,0), {tag, "_wb"});
    expCnt++;
  endtask

  task automatic runI(input logic [5:0] op, input logic [1:0] ext, input logic [2:0] alu, input string tag);
    applyStimulus(op, 6'h00, 1'b0);
    fetchDecode(1'b0, tag);
    step(mk(0,0,0,0,ext,alu,1,2'b00,2'b00,2'b00,0), {tag, "_exec"});
    step(mk(0,0,1,0,ext,alu,1,2'b00,2'b00,2'b00,0), {tag, "_wb"});
    expCnt++;
  endtask

  task automatic runNop(input string tag);
    applyStimulus(OP_RTYPE, FN_NOP, 1'b0);
    fetchDecode(1'b0, tag);
    expCnt++;
  endtask

  logic [16:0] wMemAddr;
  logic [16:0] wZero;

  initial begin
    wMemAddr = mk(0,0,0,0,2'b01,3'b000,1,2'b00,2'b00,2'b00,0);
    wZero    = '0;
    applyStimulus(6'h00, 6'h00, 1'b0);
`ifdef MC_CTRL_STALL_EN
    bus.mem_ready = 1'b1;
`endif
    @(posedge clk);
    #1;
    step(wZero, "in_reset0");
    step(wZero, "in_reset1");
    reset = 1'b0;

    runR(FN_ADDU, 3'b000, "addu");
    runR(FN_SUBU, 3'b001, "subu");
    runI(OP_LUI, 2'b10, 3'b011, "lui");
    runI(OP_ORI, 2'b00, 3'b010, "ori");

    applyStimulus(OP_LW, 6'h00, 1'b0);
    fetchDecode(1'b0, "lw");
    step(wMemAddr, "lw_addr");
    step(wZero, "lw_rd");
    step(mk(0,0,1,0,2'b00,3'b000,0,2'b00,2'b01,2'b00,0), "lw_wb");
    expCnt++;

    applyStimulus(OP_SW, 6'h00, 1'b0);
    fetchDecode(1'b0, "sw");
    step(wMemAddr, "sw_addr");
    step(mk(0,0,0,1,2'b00,3'b000,0,2'b00,2'b00,2'b00,0), "sw_wr");
    expCnt++;

    applyStimulus(OP_BEQ, 6'h00, 1'b1);
    fetchDecode(1'b0, "beq_t");
    step(mk(1,0,0,0,2'b00,3'b001,0,2'b00,2'b00,2'b01,0), "beq_t_br");
    expCnt++;
    applyStimulus(OP_BEQ, 6'h00, 1'b0);
    fetchDecode(1'b0, "beq_nt");
    step(mk(0,0,0,0,2'b00,3'b001,0,2'b00,2'b00,2'b01,0), "beq_nt_br");
    expCnt++;

    applyStimulus(OP_J, 6'h00, 1'b0);
    fetchDecode(1'b0, "j");
    step(mk(1,0,0,0,2'b00,3'b000,0,2'b00,2'b00,2'b10,0), "j_jump");
    expCnt++;
    applyStimulus(OP_JAL, 6'h00, 1'b0);
    fetchDecode(1'b0, "jal");
    step(mk(1,0,1,0,2'b00,3'b000,0,2'b10,2'b10,2'b10,0), "jal_jump");
    expCnt++;
    applyStimulus(OP_RTYPE, FN_JR, 1'b0);
    fetchDecode(1'b0, "jr");
    step(mk(1,0,0,0,2'b00,3'b000,0,2'b00,2'b00,2'b11,0), "jr_jump");
    expCnt++;

    runNop("nop12");

    applyStimulus(6'h3F, 6'h00, 1'b0);
    fetchDecode(1'b1, "ill_op3f");
    applyStimulus(OP_RTYPE, 6'h2A, 1'b0);
    fetchDecode(1'b1, "ill_fn2a");

    runNop("nop13");
    runNop("nop14");
    runNop("nop15");
    runNop("nop_wrap");
    step(mk(1,1,0,0,2'b00,3'b000,0,2'b00,2'b00,2'b00,0), "after_wrap_fetch");
    step(mk(0,0,0,0,2'b01,3'b000,0,2'b00,2'b00,2'b00,0), "after_wrap_decode");
    expCnt++;

    // Reset asserted while the load sits in MEM_RD.
    applyStimulus(OP_LW, 6'h00, 1'b0);
    fetchDecode(1'b0, "lw_rst");
    step(wMemAddr, "lw_rst_addr");
    reset  = 1'b1;
    expCnt = '0;
    step(wZero, "rst_memrd0");
    step(wZero, "rst_memrd1");
    reset = 1'b0;
    runR(FN_ADDU, 3'b000, "post_rst_addu");

`ifdef MC_CTRL_STALL_EN
    applyStimulus(OP_SW, 6'h00, 1'b0);
    bus.mem_ready = 1'b0;
    step(wZero, "st_fetch_wait");
    bus.mem_ready = 1'b1;
    fetchDecode(1'b0, "st_sw");
    step(wMemAddr, "st_sw_addr");
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(wZero, "st_sw_wait");
    bus.mem_ready = 1'b1;
    step(mk(0,0,0,1,2'b00,3'b000,0,2'b00,2'b00,2'b00,0), "st_sw_wr");
    expCnt++;
`endif

    step(mk(1,1,0,0,2'b00,3'b000,0,2'b00,2'b00,2'b00,0), "final_fetch");
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
